serial_tx: RTL and testbench

Clocked serial shifter, one stage downstream of the slow-clock generator. It consumes the generated slow clock as a bit-rate reference, latches a parallel word, and shifts it out MSB-first. Data changes on the falling edge of the serial clock, and the receiver samples on the rising edge. It also drives a gated copy of the serial clock that toggles only while bits are being sent. Typical sinks are shift-register display drivers and SPI-style peripherals.

---
 rtl/serial_tx_pkg.sv | 15 +
 rtl/clk_edge_detect.sv | 28 ++
 rtl/serial_tx.sv | 130 +++++++++++++
 tb/tb_serial_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared state type and sizing helper for the serial_tx shifter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    READY,
    WAIT,
    TRANSMIT
  } t_serial_tx_state;

  // Bit counter must reach BITS, the parity slot index when parity is compiled in.
  function automatic int cntWidth(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Two-flop synchroniser/edge detector for the slow serial reference clock.
module clk_edge_detect (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_sig,
  output logic out_sig,
  output logic out_rise,
  output logic out_fall
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= in_sig;
      s1_q <= s0_q;
    end
  end

  assign out_sig  = s0_q;
  assign out_rise = ~s1_q & s0_q;
  assign out_fall = s1_q & ~s0_q;

endmodule

// File: rtl/serial_tx.sv
// MSB-first serial shifter clocked by a slow reference; emits a gated serial clock.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int BITS                = 8,
  parameter bit SERIAL_CLK_INACTIVE = 1'b1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_enable,
  input  logic [BITS-1:0] in_parallel,
  output logic            out_ready,
  output logic            out_busy,
  output logic            out_serial_clk,
  output logic            out_serial,
  output logic            out_word_finished
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = BITS + 1;
`else
  localparam int NBITS = BITS;
`endif
  localparam int            CntW    = cntWidth(BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(NBITS - 1);

  t_serial_tx_state  state_q;
  logic [NBITS-1:0]  shiftReg_q;
  logic [CntW-1:0]   bitCount_q;
  logic              ready_q;
  logic              busy_q;
  logic              serialClk_q;
  logic              serial_q;
  logic              finished_q;

  logic              sclkLevel;
  logic              sclkRise;
  logic              sclkFall;
  logic [NBITS-1:0]  loadWord;

  clk_edge_detect u_edge (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_sig   (in_serial_clk),
    .out_sig  (sclkLevel),
    .out_rise (sclkRise),
    .out_fall (sclkFall)
  );

  always_comb begin
`ifdef SERIAL_TX_PARITY_EN
    loadWord = {in_parallel, ^in_parallel};
`else
    loadWord = in_parallel;
`endif
  end

  // Outputs are registered from the synchronised level so data and clock keep their alignment.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= READY;
      shiftReg_q  <= '0;
      bitCount_q  <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      serialClk_q <= SERIAL_CLK_INACTIVE;
      serial_q    <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        READY: begin
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          serialClk_q <= SERIAL_CLK_INACTIVE;
          serial_q    <= 1'b0;
          if (in_enable) begin
            shiftReg_q <= loadWord;
            bitCount_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          serialClk_q <= SERIAL_CLK_INACTIVE;
          serial_q    <= 1'b0;
          if (sclkFall) begin
            serialClk_q <= sclkLevel;
            serial_q    <= shiftReg_q[NBITS-1];
            state_q     <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          serialClk_q <= sclkLevel;
          if (sclkFall) begin
            shiftReg_q <= {shiftReg_q[NBITS-2:0], 1'b0};
            serial_q   <= shiftReg_q[NBITS-2];
          end else if (sclkRise) begin
            // The last rising edge still reaches the pin; idle levels follow one cycle later.
            if (bitCount_q == LastBit) begin
              finished_q <= 1'b1;
              if (in_enable) begin
                shiftReg_q <= loadWord;
                bitCount_q <= '0;
                state_q    <= WAIT;
              end else begin
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= READY;
              end
            end else begin
              bitCount_q <= bitCount_q + 1'b1;
            end
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign out_ready         = ready_q;
  assign out_busy          = busy_q;
  assign out_serial_clk    = serialClk_q;
  assign out_serial        = serial_q;
  assign out_word_finished = finished_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: words issued by stimulus are checked against bits
// captured on out_serial_clk rising edges by an independent monitor.
`timescale 1ns/1ps
module tb_serial_tx;

  localparam int BITS = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = BITS + 1;
`else
  localparam int NBITS = BITS;
`endif
  localparam bit INACTIVE   = 1'b1;
  localparam int SER_PERIOD = 10;

  logic            in_clk = 1'b0;
  logic            in_rst;
  logic            in_serial_clk;
  logic            in_enable;
  logic [BITS-1:0] in_parallel;
  logic            out_ready;
  logic            out_busy;
  logic            out_serial_clk;
  logic            out_serial;
  logic            out_word_finished;

  serial_tx #(.BITS(BITS), .SERIAL_CLK_INACTIVE(INACTIVE)) dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_serial_clk     (in_serial_clk),
    .in_enable         (in_enable),
    .in_parallel       (in_parallel),
    .out_ready         (out_ready),
    .out_busy          (out_busy),
    .out_serial_clk    (out_serial_clk),
    .out_serial        (out_serial),
    .out_word_finished (out_word_finished)
  );

  always #5 in_clk = ~in_clk;

  // Slow reference: 5 in_clk cycles per half period, as from the clock generator.
  initial begin
    in_serial_clk = 1'b0;
    forever begin
      repeat (5) @(negedge in_clk);
      in_serial_clk = ~in_serial_clk;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] expQ[$];
  int          wordsDone  = 0;
  int          bitCnt     = 0;
  int          totalRises = 0;
  int          cycle      = 0;
  int          lastRise   = 0;
  int          maxGap     = 0;
  bit          haveLast   = 1'b0;
  logic [31:0] collected  = '0;
  logic        prevSclk   = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver view of a word: data bits MSB first, then even parity if compiled in.
  function automatic logic [31:0] modelWord(input int w);
`ifdef SERIAL_TX_PARITY_EN
    int ones = 0;
    for (int i = 0; i < BITS; i++) ones += (w >> i) & 1;
    return (w * 2) + (ones % 2);
`else
    return w;
`endif
  endfunction

  // Monitor: samples data on each serial clock rise and scores on the finished pulse.
  initial begin
    logic [31:0] expWord;
    forever begin
      @(posedge in_clk);
      #1;
      cycle++;
      if (in_rst) begin
        bitCnt    = 0;
        collected = '0;
        prevSclk  = out_serial_clk;
      end else begin
        if (!prevSclk && out_serial_clk) begin
          collected = {collected[30:0], out_serial};
          bitCnt++;
          totalRises++;
          if (haveLast && (cycle - lastRise) > maxGap) maxGap = cycle - lastRise;
          lastRise = cycle;
          haveLast = 1'b1;
        end
        prevSclk = out_serial_clk;
        if (out_word_finished) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_finish: got pulse with word 0x%0h, expected no pulse", collected);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("word", collected, expWord);
            checkOutput("bit_count", bitCnt, NBITS);
          end
          wordsDone++;
          bitCnt    = 0;
          collected = '0;
        end
      end
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 2000; i++) begin
      @(negedge in_clk);
      if (out_ready) break;
    end
    if (!out_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL ready_timeout: got out_ready 0, expected 1");
    end
  endtask

  task automatic applyStimulus(input logic [BITS-1:0] w);
    waitReady();
    in_parallel = w;
    in_enable   = 1'b1;
    expQ.push_back(modelWord(int'(w)));
    @(negedge in_clk);
    in_enable = 1'b0;
    checkOutput("latch_ready", out_ready, 1'b0);
    checkOutput("latch_busy", out_busy, 1'b1);
  endtask

  task automatic waitWords(input int target, input string name);
    for (int i = 0; i < 3000; i++) begin
      if (wordsDone >= target) break;
      @(negedge in_clk);
    end
    checkOutput(name, wordsDone >= target, 1'b1);
  endtask

  task automatic waitBits(input int n);
    for (int i = 0; i < 1000; i++) begin
      if (bitCnt >= n) break;
      @(negedge in_clk);
    end
    checkOutput("bits_reached", bitCnt >= n, 1'b1);
  endtask

  initial begin
    int base;
    int r0;
    int sawReady;
    int badClk;
    int badSer;
    int badBusy;

    in_rst      = 1'b1;
    in_enable   = 1'b0;
    in_parallel = '0;
    repeat (3) @(negedge in_clk);
    checkOutput("rst_ready", out_ready, 1'b1);
    checkOutput("rst_busy", out_busy, 1'b0);
    checkOutput("rst_serial", out_serial, 1'b0);
    checkOutput("rst_sclk", out_serial_clk, INACTIVE);
    checkOutput("rst_finished", out_word_finished, 1'b0);
    in_rst = 1'b0;

    // Single word
    base = wordsDone;
    applyStimulus(8'hA5);
    waitWords(base + 1, "single_done");
    checkOutput("single_ready_after", out_ready, 1'b1);

    // Back-to-back with enable held across the first word
    waitReady();
    haveLast    = 1'b0;
    maxGap      = 0;
    r0          = totalRises;
    base        = wordsDone;
    sawReady    = 0;
    in_parallel = 8'h3C;
    in_enable   = 1'b1;
    expQ.push_back(modelWord(32'h3C));
    expQ.push_back(modelWord(32'hC3));
    @(negedge in_clk);
    in_parallel = 8'hC3;
    for (int i = 0; i < 1000; i++) begin
      if (wordsDone >= base + 1) in_enable = 1'b0;
      if (wordsDone >= base + 2) break;
      if (out_ready) sawReady++;
      @(negedge in_clk);
    end
    in_enable = 1'b0;
    checkOutput("b2b_done", wordsDone, base + 2);
    checkOutput("b2b_ready_low", sawReady, 0);
    checkOutput("b2b_pulses", totalRises - r0, 2 * NBITS);
    checkOutput("b2b_max_gap", maxGap, SER_PERIOD);

    // Input stability: parallel input changes mid-word
    base = wordsDone;
    applyStimulus(8'h12);
    waitBits(2);
    in_parallel = 8'hFF;
    waitWords(base + 1, "stable_done");

    // Mid-transfer asynchronous reset
    applyStimulus(8'h5A);
    waitBits(3);
    @(posedge in_clk);
    #3;
    in_rst = 1'b1;
    expQ.delete();
    base = wordsDone;
    #1;
    checkOutput("mrst_ready", out_ready, 1'b1);
    checkOutput("mrst_busy", out_busy, 1'b0);
    checkOutput("mrst_serial", out_serial, 1'b0);
    checkOutput("mrst_sclk", out_serial_clk, INACTIVE);
    checkOutput("mrst_finished", out_word_finished, 1'b0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    checkOutput("mrst_no_finish", wordsDone, base);
    applyStimulus(8'h81);
    waitWords(base + 1, "after_rst_done");

    // Parity-sensitive word
    base = wordsDone;
    applyStimulus(8'h07);
    waitWords(base + 1, "parity_word_done");

    // Random words with random idle gaps
    for (int k = 0; k < 12; k++) begin
      base = wordsDone;
      repeat ($urandom_range(0, 7)) @(negedge in_clk);
      applyStimulus(8'($urandom_range(0, 255)));
      waitWords(base + 1, "rand_done");
    end

    // Idle
    waitReady();
    badClk  = 0;
    badSer  = 0;
    badBusy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge in_clk);
      if (out_serial_clk !== INACTIVE) badClk++;
      if (out_serial !== 1'b0) badSer++;
      if (out_busy !== 1'b0) badBusy++;
    end
    checkOutput("idle_sclk", badClk, 0);
    checkOutput("idle_serial", badSer, 0);
    checkOutput("idle_busy", badBusy, 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
